// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter between the ICache and the load/store buffer.
// Define IO_BUF_STALL_EN to hold IO stores (0x30000/0x30004) while io_buffer_full is set.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              req_ic_in,
  input  logic [ADDR_W-1:0] addr_ic_in,
  output logic              done_ic_out,
  output logic [31:0]       data_ic_out,
  input  logic              req_lsb_in,
  input  logic              wr_lsb_in,
  input  logic [1:0]        size_lsb_in,
  input  logic [ADDR_W-1:0] addr_lsb_in,
  input  logic [31:0]       data_lsb_in,
  output logic              done_lsb_out,
  output logic [31:0]       data_lsb_out,
`ifdef IO_BUF_STALL_EN
  input  logic              io_buffer_full,
`endif
  input  logic              refresh_rob_cdb_in
);

  // state  | meaning
  // IDLE   | no transfer; arbitrate when no done pulse and no flush
  // IC_RD  | 4-byte instruction fetch, cnt = byte being captured
  // LSB_RD | 1/2/4-byte load, cnt = byte being captured
  // LSB_WR | 1/2/4-byte store, cnt = byte on the bus
  typedef enum logic [1:0] {IDLE, IC_RD, LSB_RD, LSB_WR} state_t;

  localparam logic GRANT_IC  = 1'b0;
  localparam logic GRANT_LSB = 1'b1;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt, len, len_nxt, idx_nxt, lsb_len;
  logic [ADDR_W-1:0] base, base_nxt, mem_a_nxt;
  logic              last_grant, last_grant_nxt;
  logic [31:0]       wbuf, wbuf_nxt, rbuf, rbuf_nxt, rbuf_cap;
  logic [31:0]       data_ic_nxt, data_lsb_nxt;
  logic [7:0]        mem_dout_nxt;
  logic              mem_wr_nxt, done_ic_nxt, done_lsb_nxt;
  logic              lsb_stall, lsb_ok, grant_lsb, grant_ic;

  always_comb begin
`ifdef IO_BUF_STALL_EN
    lsb_stall = io_buffer_full & wr_lsb_in &
                ((addr_lsb_in == ADDR_W'(32'h30000)) | (addr_lsb_in == ADDR_W'(32'h30004)));
`else
    lsb_stall = 1'b0;
`endif
    lsb_ok    = req_lsb_in & ~lsb_stall;
    grant_lsb = lsb_ok & (~req_ic_in | (last_grant == GRANT_IC));
    grant_ic  = req_ic_in & ~grant_lsb;
    case (size_lsb_in)
      2'd0:    lsb_len = 3'd1;
      2'd1:    lsb_len = 3'd2;
      default: lsb_len = 3'd4;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    len_nxt        = len;
    base_nxt       = base;
    last_grant_nxt = last_grant;
    wbuf_nxt       = wbuf;
    rbuf_nxt       = rbuf;
    mem_a_nxt      = mem_a;
    mem_dout_nxt   = mem_dout;
    mem_wr_nxt     = mem_wr;
    data_ic_nxt    = data_ic_out;
    data_lsb_nxt   = data_lsb_out;
    done_ic_nxt    = 1'b0;
    done_lsb_nxt   = 1'b0;
    idx_nxt        = cnt + 3'd1;
    rbuf_cap       = rbuf;
    rbuf_cap[{cnt[1:0], 3'b000} +: 8] = mem_din;

    case (state)
      IDLE: begin
        // A done pulse still high means the requester has not yet dropped its level.
        if (!done_ic_out && !done_lsb_out && !refresh_rob_cdb_in) begin
          if (grant_lsb) begin
            last_grant_nxt = GRANT_LSB;
            base_nxt       = addr_lsb_in;
            len_nxt        = lsb_len;
            cnt_nxt        = 3'd0;
            mem_a_nxt      = addr_lsb_in;
            rbuf_nxt       = 32'd0;
            if (wr_lsb_in) begin
              wbuf_nxt     = data_lsb_in;
              mem_dout_nxt = data_lsb_in[7:0];
              mem_wr_nxt   = 1'b1;
              state_nxt    = LSB_WR;
            end else begin
              mem_wr_nxt   = 1'b0;
              state_nxt    = LSB_RD;
            end
          end else if (grant_ic) begin
            last_grant_nxt = GRANT_IC;
            base_nxt       = addr_ic_in;
            len_nxt        = 3'd4;
            cnt_nxt        = 3'd0;
            mem_a_nxt      = addr_ic_in;
            rbuf_nxt       = 32'd0;
            mem_wr_nxt     = 1'b0;
            state_nxt      = IC_RD;
          end
        end
      end
      IC_RD, LSB_RD: begin
        if (refresh_rob_cdb_in) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else begin
          rbuf_nxt = rbuf_cap;
          cnt_nxt  = idx_nxt;
          if (idx_nxt == len) begin
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
            if (state == IC_RD) begin
              done_ic_nxt = 1'b1;
              data_ic_nxt = rbuf_cap;
            end else begin
              done_lsb_nxt = 1'b1;
              data_lsb_nxt = rbuf_cap;
            end
          end else begin
            mem_a_nxt = base + ADDR_W'(idx_nxt);
          end
        end
      end
      LSB_WR: begin
        // Stores here are committed, so a flush does not stop them.
        if (idx_nxt == len) begin
          mem_wr_nxt   = 1'b0;
          done_lsb_nxt = 1'b1;
          state_nxt    = IDLE;
          cnt_nxt      = 3'd0;
        end else begin
          cnt_nxt      = idx_nxt;
          mem_a_nxt    = base + ADDR_W'(idx_nxt);
          mem_dout_nxt = wbuf[{idx_nxt[1:0], 3'b000} +: 8];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      len          <= 3'd0;
      base         <= '0;
      last_grant   <= GRANT_IC;
      wbuf         <= 32'd0;
      rbuf         <= 32'd0;
      mem_a        <= '0;
      mem_dout     <= 8'd0;
      mem_wr       <= 1'b0;
      done_ic_out  <= 1'b0;
      done_lsb_out <= 1'b0;
      data_ic_out  <= 32'd0;
      data_lsb_out <= 32'd0;
    end else if (rdy_in) begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      len          <= len_nxt;
      base         <= base_nxt;
      last_grant   <= last_grant_nxt;
      wbuf         <= wbuf_nxt;
      rbuf         <= rbuf_nxt;
      mem_a        <= mem_a_nxt;
      mem_dout     <= mem_dout_nxt;
      mem_wr       <= mem_wr_nxt;
      done_ic_out  <= done_ic_nxt;
      done_lsb_out <= done_lsb_nxt;
      data_ic_out  <= data_ic_nxt;
      data_lsb_out <= data_lsb_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-timeline reference model. Build with IO_BUF_STALL_EN to cover the IO stall.
module tb_mem_arbiter;
  localparam int AW = 32;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in;
  logic [7:0]    mem_din, mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_wr;
  logic          req_ic_in, done_ic_out;
  logic [AW-1:0] addr_ic_in, addr_lsb_in;
  logic [31:0]   data_ic_out, data_lsb_in, data_lsb_out;
  logic          req_lsb_in, wr_lsb_in, done_lsb_out, refresh_rob_cdb_in;
  logic [1:0]    size_lsb_in;
`ifdef IO_BUF_STALL_EN
  logic          io_buffer_full;
`endif

  always #5 clk_in = ~clk_in;

  mem_arbiter #(.ADDR_W(AW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .req_ic_in(req_ic_in), .addr_ic_in(addr_ic_in),
    .done_ic_out(done_ic_out), .data_ic_out(data_ic_out),
    .req_lsb_in(req_lsb_in), .wr_lsb_in(wr_lsb_in), .size_lsb_in(size_lsb_in),
    .addr_lsb_in(addr_lsb_in), .data_lsb_in(data_lsb_in),
    .done_lsb_out(done_lsb_out), .data_lsb_out(data_lsb_out),
`ifdef IO_BUF_STALL_EN
    .io_buffer_full(io_buffer_full),
`endif
    .refresh_rob_cdb_in(refresh_rob_cdb_in)
  );

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // RAM seen by the DUT, and the model's own copy of what memory should hold
  logic [7:0] ram    [logic [31:0]];
  logic [7:0] shadow [logic [31:0]];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5a;
  endfunction
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction
  function automatic logic [7:0] shadow_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : dflt(a);
  endfunction
  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      ram[a + 32'(i)]    = w[8*i +: 8];
      shadow[a + 32'(i)] = w[8*i +: 8];
    end
  endtask

  // Reference model: a transaction is an accept edge plus j active edges since then.
  bit          m_busy, m_who, m_wr, m_last, kill_ic, kill_lsb;
  int          m_n, m_j;
  logic [31:0] m_base, m_wdata, m_result;
  logic [31:0] exp_a, exp_data_ic, exp_data_lsb;
  logic [7:0]  exp_dout;
  bit          exp_wr, exp_dic, exp_dlsb;

  task automatic model_reset();
    m_busy = 0; m_last = 0; kill_ic = 0; kill_lsb = 0;
    exp_a = 0; exp_dout = 0; exp_wr = 0; exp_dic = 0; exp_dlsb = 0;
    exp_data_ic = 0; exp_data_lsb = 0;
  endtask

  task automatic model_step();
    bit prev_done, ic_ok, lsb_ok, stall;
    kill_ic = 0; kill_lsb = 0;
    if (rst_in || !rdy_in) return;
    prev_done = exp_dic || exp_dlsb;
    exp_dic = 0; exp_dlsb = 0;
    if (m_busy) begin
      m_j++;
      if (!m_wr && refresh_rob_cdb_in) begin
        m_busy = 0;
        if (m_who) kill_lsb = 1; else kill_ic = 1;
      end else if (m_j == m_n) begin
        m_busy = 0;
        if (m_wr) begin exp_wr = 0; exp_dlsb = 1; end
        else if (m_who) begin exp_dlsb = 1; exp_data_lsb = m_result; end
        else begin exp_dic = 1; exp_data_ic = m_result; end
      end else begin
        exp_a = m_base + 32'(m_j);
        if (m_wr) begin
          exp_dout = m_wdata[8*m_j +: 8];
          shadow[exp_a] = exp_dout;
        end
      end
    end else if (!prev_done && !refresh_rob_cdb_in) begin
      stall = 0;
`ifdef IO_BUF_STALL_EN
      stall = io_buffer_full && wr_lsb_in &&
              (addr_lsb_in == 32'h30000 || addr_lsb_in == 32'h30004);
`endif
      ic_ok  = req_ic_in;
      lsb_ok = req_lsb_in && !stall;
      if (ic_ok || lsb_ok) begin
        m_who  = (ic_ok && lsb_ok) ? !m_last : lsb_ok;
        m_last = m_who;
        m_busy = 1; m_j = 0;
        if (m_who) begin
          m_base = addr_lsb_in; m_wr = wr_lsb_in; m_wdata = data_lsb_in;
          m_n = (size_lsb_in == 0) ? 1 : (size_lsb_in == 1) ? 2 : 4;
        end else begin
          m_base = addr_ic_in; m_wr = 0; m_n = 4;
        end
        exp_a = m_base; exp_wr = m_wr;
        if (m_wr) begin
          exp_dout = m_wdata[7:0];
          shadow[exp_a] = exp_dout;
        end else begin
          m_result = 0;
          for (int i = 0; i < m_n; i++)
            m_result |= 32'(shadow_rd(m_base + 32'(i))) << (8*i);
        end
      end
    end
  endtask

  task automatic compare();
    check_eq("mem_a", mem_a, exp_a);
    check_eq("mem_wr", 32'(mem_wr), 32'(exp_wr));
    check_eq("mem_dout", 32'(mem_dout), 32'(exp_dout));
    check_eq("done_ic", 32'(done_ic_out), 32'(exp_dic));
    check_eq("done_lsb", 32'(done_lsb_out), 32'(exp_dlsb));
    check_eq("data_ic", data_ic_out, exp_data_ic);
    check_eq("data_lsb", data_lsb_out, exp_data_lsb);
  endtask

  task automatic env_update();
    if (mem_wr === 1'b1) ram[mem_a] = mem_dout;
    mem_din = ram_rd(mem_a);
  endtask

  // One clock: predict the edge, let it happen, check at the next falling edge.
  task automatic cycle();
    model_step();
    @(negedge clk_in);
    compare();
    env_update();
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    #1;
    model_reset();
    compare();
    req_ic_in = 0; req_lsb_in = 0;
    @(negedge clk_in);
    rst_in = 1'b0;
    env_update();
  endtask

  task automatic lsb_req(input bit wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    req_lsb_in = 1; wr_lsb_in = wr; size_lsb_in = sz; addr_lsb_in = a; data_lsb_in = d;
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFE;
      1:       return ($urandom_range(0, 1) != 0) ? 32'h30000 : 32'h30004;
      default: return 32'($urandom_range(0, 511));
    endcase
  endfunction

  task automatic agents();
    if (exp_dic || kill_ic) req_ic_in = 0;
    if (exp_dlsb || kill_lsb) req_lsb_in = 0;
    if (!exp_dic && !exp_dlsb) begin
      if (!req_ic_in && $urandom_range(0, 3) == 0) begin
        req_ic_in = 1; addr_ic_in = rnd_addr();
      end
      if (!req_lsb_in && $urandom_range(0, 3) == 0)
        lsb_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rnd_addr(), $urandom);
    end
  endtask

  initial begin
    rst_in = 1; rdy_in = 1; mem_din = 0; refresh_rob_cdb_in = 0;
    req_ic_in = 0; addr_ic_in = 0; req_lsb_in = 0; wr_lsb_in = 0;
    size_lsb_in = 0; addr_lsb_in = 0; data_lsb_in = 0;
`ifdef IO_BUF_STALL_EN
    io_buffer_full = 0;
`endif
    model_reset();
    @(negedge clk_in);
    compare();
    @(negedge clk_in);
    rst_in = 0;
    env_update();

    // IC fetch at 0x100
    preload(32'h100, 32'h0000_0513);
    req_ic_in = 1; addr_ic_in = 32'h100;
    cycle();
    check_eq("t1_a0", mem_a, 32'h100);
    for (int k = 1; k < 4; k++) begin
      cycle();
      check_eq("t1_addr", mem_a, 32'h100 + 32'(k));
      check_eq("t1_early_done", 32'(done_ic_out), 0);
    end
    cycle();
    check_eq("t1_done", 32'(done_ic_out), 1);
    check_eq("t1_data", data_ic_out, 32'h0000_0513);
    req_ic_in = 0;
    cycle();
    check_eq("t1_pulse_len", 32'(done_ic_out), 0);

    // single-byte store
    lsb_req(1, 2'd0, 32'h2000, 32'hAABB_CCDD);
    cycle();
    check_eq("t2_wr", 32'(mem_wr), 1);
    check_eq("t2_a", mem_a, 32'h2000);
    check_eq("t2_dout", 32'(mem_dout), 32'hDD);
    cycle();
    check_eq("t2_wr_off", 32'(mem_wr), 0);
    check_eq("t2_done", 32'(done_lsb_out), 1);
    req_lsb_in = 0;
    cycle();

    // tie after reset: LSB first, IC right after the done cycle
    do_reset();
    preload(32'h40, 32'h0000_BEEF);
    req_ic_in = 1; addr_ic_in = 32'h100;
    lsb_req(0, 2'd1, 32'h40, 32'h0);
    cycle();
    check_eq("t3_lsb_first", mem_a, 32'h40);
    cycle();
    cycle();
    check_eq("t3_done_lsb", 32'(done_lsb_out), 1);
    check_eq("t3_data_lsb", data_lsb_out, 32'h0000_BEEF);
    req_lsb_in = 0;
    cycle();
    check_eq("t3_blocked", mem_a, 32'h41);
    cycle();
    check_eq("t3_ic_grant", mem_a, 32'h100);
    repeat (4) cycle();
    check_eq("t3_ic_data", data_ic_out, 32'h0000_0513);
    req_ic_in = 0;
    cycle();

    // flush mid-fetch discards the read
    preload(32'h280, 32'hCAFE_F00D);
    req_ic_in = 1; addr_ic_in = 32'h280;
    cycle(); cycle(); cycle();
    refresh_rob_cdb_in = 1;
    cycle();
    check_eq("t4_flush_a", mem_a, 32'h282);
    refresh_rob_cdb_in = 0; req_ic_in = 0;
    repeat (3) begin
      cycle();
      check_eq("t4_no_done", 32'(done_ic_out), 0);
    end
    check_eq("t4_data_hold", data_ic_out, 32'h0000_0513);

    // flush does not stop a store
    lsb_req(1, 2'd2, 32'h300, 32'h1122_3344);
    cycle();
    refresh_rob_cdb_in = 1;
    for (int k = 1; k < 4; k++) begin
      cycle();
      check_eq("t4_st_wr", 32'(mem_wr), 1);
      check_eq("t4_st_a", mem_a, 32'h300 + 32'(k));
    end
    cycle();
    check_eq("t4_st_done", 32'(done_lsb_out), 1);
    refresh_rob_cdb_in = 0; req_lsb_in = 0;
    cycle();
    check_eq("t4_st_ram", 32'(ram_rd(32'h303)), 32'h11);

    // rdy_in low mid-read
    preload(32'h200, 32'h1234_5678);
    req_ic_in = 1; addr_ic_in = 32'h200;
    cycle(); cycle();
    rdy_in = 0;
    repeat (3) begin
      cycle();
      check_eq("t5_frozen_a", mem_a, 32'h201);
    end
    rdy_in = 1;
    cycle(); cycle(); cycle();
    check_eq("t5_done", 32'(done_ic_out), 1);
    check_eq("t5_data", data_ic_out, 32'h1234_5678);
    req_ic_in = 0;
    cycle();

    // reset during a store
    lsb_req(1, 2'd2, 32'h400, 32'h5566_7788);
    cycle(); cycle();
    do_reset();
    check_eq("t6_wr_off", 32'(mem_wr), 0);
    check_eq("t6_a_rst", mem_a, 32'h0);
    cycle();
    check_eq("t6_no_done", 32'(done_lsb_out), 0);

`ifdef IO_BUF_STALL_EN
    io_buffer_full = 1;
    lsb_req(1, 2'd1, 32'h30000, 32'h0000_A1B2);
    req_ic_in = 1; addr_ic_in = 32'h100;
    cycle();
    check_eq("t7_ic_first", mem_a, 32'h100);
    repeat (4) cycle();
    check_eq("t7_ic_done", 32'(done_ic_out), 1);
    req_ic_in = 0;
    cycle(); cycle();
    check_eq("t7_held", 32'(mem_wr), 0);
    io_buffer_full = 0;
    cycle();
    check_eq("t7_st_wr", 32'(mem_wr), 1);
    check_eq("t7_st_a", mem_a, 32'h30000);
    cycle(); cycle();
    req_lsb_in = 0;
    cycle();
`endif

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) do_reset();
      agents();
      refresh_rob_cdb_in = ($urandom_range(0, 15) == 0);
      rdy_in = ($urandom_range(0, 7) != 0);
`ifdef IO_BUF_STALL_EN
      io_buffer_full = ($urandom_range(0, 2) == 0);
`endif
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
